// File: rtl/cas_byte_feeder_if.sv
// Buffer read port and square-wave generator handshake
// shared between the byte feeder and its neighbours.
interface cas_byte_feeder_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_data;
    logic              sq_start;
    logic [7:0]        sq_din;
    logic              sq_done;

    modport master (
        output mem_addr, mem_rd, sq_start, sq_din,
        input  mem_data, sq_done
    );

    modport slave (
        input  mem_addr, mem_rd, sq_start, sq_din,
        output mem_data, sq_done
    );
endinterface

// File: rtl/cas_byte_feeder.sv
// Streams a leader of sync bytes and then a buffered tape image
// into the cassette square-wave generator, one byte per handshake.
module cas_byte_feeder #(
    parameter int          ADDR_W      = 16,
    parameter int          LEADER_LEN  = 128,
    parameter logic [7:0]  LEADER_BYTE = 8'h55
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic              motor,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              eof,
    cas_byte_feeder_if.master bus
);
    localparam int LW = (LEADER_LEN > 0) ? $clog2(LEADER_LEN + 1) : 1;
    localparam logic [LW-1:0] LLEN = LW'(LEADER_LEN);

    typedef enum logic [2:0] {
        IDLE, LEAD, FETCH, LOAD, START, ARM, WAIT, NEXT
    } state_t;

    state_t            state;
    logic              play_q;
    logic              in_lead;
    logic [LW-1:0]     lead_cnt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] len_q;

    logic [LW-1:0]     lead_nxt;
    logic [ADDR_W:0]   ptr_inc;
    logic              last;

    // Next-count arithmetic; the end test is one bit wider so ptr never wraps.
    always_comb begin
        lead_nxt = lead_cnt + LW'(1);
        ptr_inc  = {1'b0, ptr} + (ADDR_W + 1)'(1);
        last     = ~in_lead && (ptr_inc == {1'b0, len_q});
    end

    // Sequencer with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            play_q       <= 1'b0;
            in_lead      <= 1'b0;
            lead_cnt     <= '0;
            ptr          <= '0;
            len_q        <= '0;
            busy         <= 1'b0;
            eof          <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_rd   <= 1'b0;
            bus.sq_start <= 1'b0;
            bus.sq_din   <= 8'h00;
        end else begin
            play_q       <= play;
            bus.mem_rd   <= 1'b0;
            bus.sq_start <= 1'b0;
            eof          <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (play && !play_q && len != '0) begin
                        len_q    <= len;
                        ptr      <= '0;
                        lead_cnt <= '0;
                        busy     <= 1'b1;
                        if (LEADER_LEN > 0) begin
                            in_lead <= 1'b1;
                            state   <= LEAD;
                        end else begin
                            in_lead      <= 1'b0;
                            bus.mem_addr <= '0;
                            bus.mem_rd   <= 1'b1;
                            state        <= FETCH;
                        end
                    end
                end
                LEAD: begin
                    bus.sq_din   <= LEADER_BYTE;
                    bus.sq_start <= 1'b1;
                    state        <= START;
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    bus.sq_din   <= bus.mem_data;
                    bus.sq_start <= 1'b1;
                    state        <= START;
                end
                START: state <= ARM;
                // Generator drops done on start, so done is only trusted from WAIT.
                ARM:   state <= WAIT;
                WAIT: begin
                    if (bus.sq_done) begin
                        state <= NEXT;
                        eof   <= last;
                    end
                end
                NEXT: begin
                    if (last || !play) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (motor) begin
                        if (in_lead && lead_nxt < LLEN) begin
                            lead_cnt <= lead_nxt;
                            state    <= LEAD;
                        end else if (in_lead) begin
                            in_lead      <= 1'b0;
                            ptr          <= '0;
                            bus.mem_addr <= '0;
                            bus.mem_rd   <= 1'b1;
                            state        <= FETCH;
                        end else begin
                            ptr          <= ptr_inc[ADDR_W-1:0];
                            bus.mem_addr <= ptr_inc[ADDR_W-1:0];
                            bus.mem_rd   <= 1'b1;
                            state        <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cas_byte_feeder.sv
// Directed bench: table of playbacks plus stop, motor-hold
// and reset-during-wait sequences against a generator model.
module tb_cas_byte_feeder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        play = 1'b0;
    logic        motor = 1'b1;
    logic [15:0] len = '0;
    logic        busy;
    logic        eof;

    cas_byte_feeder_if #(.ADDR_W(16)) bus ();

    cas_byte_feeder #(
        .ADDR_W(16), .LEADER_LEN(2), .LEADER_BYTE(8'h55)
    ) dut (
        .clk(clk), .reset(reset), .play(play), .motor(motor),
        .len(len), .busy(busy), .eof(eof), .bus(bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Buffer model: synchronous read, one cycle latency.
    logic [7:0] mem [16];
    initial begin
        mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3; mem[3] = 8'hD4;
        for (int i = 4; i < 16; i++) mem[i] = 8'(i);
    end
    always @(posedge clk) if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr[3:0]];

    // Generator model: done low on start, high 20 cycles later.
    int gcnt = 0;
    initial bus.sq_done = 1'b1;
    always @(posedge clk) begin
        if (bus.sq_start) begin
            gcnt <= 20;
            bus.sq_done <= 1'b0;
        end else if (gcnt > 1) begin
            gcnt <= gcnt - 1;
        end else if (gcnt == 1) begin
            gcnt <= 0;
            bus.sq_done <= 1'b1;
        end
    end

    // Monitor: log starts, count eof, flag wide pulses.
    int n_st = 0;
    int st_cyc [16];
    logic [7:0] st_byte [16];
    int n_eof = 0;
    int wide = 0;
    int eof_busy_bad = 0;
    logic start_prev = 1'b0;
    logic eof_prev = 1'b0;
    always @(negedge clk) begin
        if (bus.sq_start) begin
            if (n_st < 16) begin
                st_cyc[n_st] = cyc;
                st_byte[n_st] = bus.sq_din;
            end
            n_st++;
            if (start_prev) wide++;
        end
        if (eof) begin
            n_eof++;
            if (eof_prev) wide++;
        end
        if (eof_prev && busy) eof_busy_bad++;
        start_prev = bus.sq_start;
        eof_prev = eof;
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        n_st = 0;
        n_eof = 0;
        wide = 0;
        eof_busy_bad = 0;
    endtask

    typedef struct {
        logic [15:0]     len;
        bit              hold;
        logic [5:0][7:0] exp;
        int              exp_n;
        bit              exp_eof;
    } vec_t;

    vec_t vecs [5];

    task automatic run_vec(input vec_t v, input int idx);
        int play_n;
        int rel;
        bit done_ok;
        clear_log();
        len = v.len;
        @(negedge clk);
        play = 1'b1;
        play_n = cyc;
        done_ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (v.hold && n_st >= 4) begin
                rel = cyc - st_cyc[3];
                motor = !(rel >= 22 && rel <= 71);
            end
            if (cyc > play_n + 2 && !busy) begin
                done_ok = 1'b1;
                break;
            end
        end
        motor = 1'b1;
        chk($sformatf("v%0d_finish", idx), int'(done_ok), 1);
        repeat (30) @(negedge clk);
        play = 1'b0;
        chk($sformatf("v%0d_nstart", idx), n_st, v.exp_n);
        for (int i = 0; i < v.exp_n && i < n_st; i++)
            chk($sformatf("v%0d_byte%0d", idx, i), int'(st_byte[i]), int'(v.exp[5 - i]));
        chk($sformatf("v%0d_eof", idx), n_eof, int'(v.exp_eof));
        chk($sformatf("v%0d_wide", idx), wide, 0);
        chk($sformatf("v%0d_busy_after_eof", idx), eof_busy_bad, 0);
        if (v.exp_n > 0 && n_st > 0)
            chk($sformatf("v%0d_lat", idx), st_cyc[0] - play_n, 2);
        if (v.exp_n >= 5 && n_st >= 5) begin
            chk($sformatf("v%0d_gap_ll", idx), st_cyc[1] - st_cyc[0], 24);
            chk($sformatf("v%0d_gap_li", idx), st_cyc[2] - st_cyc[1], 25);
            chk($sformatf("v%0d_gap_ii", idx), st_cyc[4] - st_cyc[3],
                v.hold ? 75 : 25);
        end
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{16'd3, 1'b0,
            {8'h55, 8'h55, 8'hA1, 8'hB2, 8'hC3, 8'h00}, 5, 1'b1};
        vecs[1] = '{16'd0, 1'b0,
            {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 1'b0};
        vecs[2] = '{16'd1, 1'b0,
            {8'h55, 8'h55, 8'hA1, 8'h00, 8'h00, 8'h00}, 3, 1'b1};
        vecs[3] = '{16'd4, 1'b0,
            {8'h55, 8'h55, 8'hA1, 8'hB2, 8'hC3, 8'hD4}, 6, 1'b1};
        vecs[4] = '{16'd3, 1'b1,
            {8'h55, 8'h55, 8'hA1, 8'hB2, 8'hC3, 8'h00}, 5, 1'b1};

        #12;
        chk("rst_sq_start", int'(bus.sq_start), 0);
        chk("rst_sq_din", int'(bus.sq_din), 0);
        chk("rst_mem_rd", int'(bus.mem_rd), 0);
        chk("rst_mem_addr", int'(bus.mem_addr), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_eof", int'(eof), 0);
        @(negedge clk);
        reset = 1'b0;

        clear_log();
        repeat (1000) @(negedge clk);
        chk("idle_nstart", n_st, 0);
        chk("idle_eof", n_eof, 0);
        chk("idle_busy", int'(busy), 0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Stop during the second leader byte.
        clear_log();
        len = 16'd3;
        @(negedge clk);
        play = 1'b1;
        for (int k = 0; k < 400 && n_st < 2; k++) @(negedge clk);
        chk("stop_reach", int'(n_st >= 2), 1);
        play = 1'b0;
        for (int k = 0; k < 400 && busy; k++) @(negedge clk);
        chk("stop_idle", int'(busy), 0);
        repeat (30) @(negedge clk);
        chk("stop_nstart", n_st, 2);
        chk("stop_eof", n_eof, 0);
        chk("stop_byte1", int'(st_byte[1]), 8'h55);
        run_vec(vecs[0], 10);

        // Reset while waiting on the generator.
        clear_log();
        @(negedge clk);
        play = 1'b1;
        for (int k = 0; k < 400 && n_st < 3; k++) @(negedge clk);
        chk("rw_reach", int'(n_st >= 3), 1);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rw_sq_start", int'(bus.sq_start), 0);
        chk("rw_busy", int'(busy), 0);
        chk("rw_mem_rd", int'(bus.mem_rd), 0);
        chk("rw_sq_din", int'(bus.sq_din), 0);
        @(negedge clk);
        play = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("rw_eof", n_eof, 0);
        chk("rw_idle", int'(busy), 0);
        run_vec(vecs[0], 11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
